// File: rtl/sd_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sd_frame_pkg
// Description : Shared constants and drain FSM encoding for sd_frame_writer.
// Revision    : 1.0 - initial release
// ============================================================================
package sd_frame_pkg;

    localparam int          SEC_WORDS     = 256;
    localparam logic [31:0] DEF_START_SEC = 32'd16384;
    localparam logic [15:0] DEF_SEC_NUM   = 16'd1200;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_FULL = 3'd1,
        S_START     = 3'd2,
        S_XFER      = 3'd3,
        S_RELEASE   = 3'd4
    } drain_state_t;

endpackage
`default_nettype wire

// File: rtl/sd_pingpong_ram.sv
`default_nettype none
// ============================================================================
// Module      : sd_pingpong_ram
// Description : 2x256x16 simple dual-port RAM, address {bank,ptr}, one write
//               port and one registered read port (single block RAM).
// Revision    : 1.0 - initial release
// ============================================================================
module sd_pingpong_ram (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wr_en,
    input  logic [8:0]  i_wr_addr,
    input  logic [15:0] i_wr_data,
    input  logic        i_rd_en,
    input  logic [8:0]  i_rd_addr,
    output logic [15:0] o_rd_data
);

    logic [15:0] r_mem [0:511];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Output register holds its word between reads so it can drive the engine directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_rd_data <= 16'd0;
        end else if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/sd_frame_writer.sv
`default_nettype none
// ============================================================================
// Module      : sd_frame_writer
// Description : Packs a 16-bit pixel stream into ping-pong 256-word sectors
//               and feeds the sd_write engine one sector per CMD24.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_frame_writer
    import sd_frame_pkg::*;
#(
    parameter logic [31:0] START_SEC = DEF_START_SEC,
    parameter logic [15:0] SEC_NUM   = DEF_SEC_NUM
) (
    input  logic        clk_ref,
    input  logic        rst,
    input  logic        capture_start,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    input  logic        wr_busy,
    input  logic        wr_req,
    output logic        wr_start_en,
    output logic [31:0] wr_sec_addr,
    output logic [15:0] wr_data,
    output logic        frame_busy,
    output logic        frame_done,
    output logic        overflow
);

    localparam logic [31:0] c_frame_words = 32'(SEC_NUM) * 32'(SEC_WORDS);

    drain_state_t r_state;
    logic         r_fill_bank;
    logic         r_drain_bank;
    logic [7:0]   r_wr_ptr;
    logic [31:0]  r_pix_cnt;
    logic [1:0]   r_full;
    logic [8:0]   r_rd_ptr;
    logic [15:0]  r_sec_idx;
    logic         r_busy_d;

    logic         w_capture_ok;
    logic         w_fill_en;
    logic         w_ram_we;
    logic         w_drop;
    logic         w_set_full;
    logic         w_release;
    logic [1:0]   w_full_nxt;
    logic         w_rd_en;
    logic [8:0]   w_rd_addr;
    logic [15:0]  w_sec_next;

    assign w_capture_ok = capture_start & ~frame_busy;
    assign w_fill_en    = frame_busy & pix_valid & (r_pix_cnt < c_frame_words);
    assign w_drop       = w_fill_en & r_full[r_fill_bank];
    assign w_ram_we     = w_fill_en & ~r_full[r_fill_bank];
    assign w_set_full   = w_ram_we & (r_wr_ptr == 8'hFF);
    assign w_release    = (r_state == S_RELEASE);
    assign w_sec_next   = r_sec_idx + 16'd1;

    // Release is applied last so it wins on the bank being drained.
    always_comb begin
        w_full_nxt = r_full;
        if (w_set_full) begin
            w_full_nxt[r_fill_bank] = 1'b1;
        end
        if (w_release) begin
            w_full_nxt[r_drain_bank] = 1'b0;
        end
    end

    // Word 0 is fetched while leaving WAIT_FULL so it is on wr_data before wr_start_en rises.
    always_comb begin
        w_rd_en   = 1'b0;
        w_rd_addr = {r_drain_bank, 8'd0};
        if ((r_state == S_WAIT_FULL) && r_full[r_drain_bank]) begin
            w_rd_en = 1'b1;
        end else if ((r_state == S_XFER) && wr_req && !r_rd_ptr[8]) begin
            w_rd_en   = 1'b1;
            w_rd_addr = {r_drain_bank, r_rd_ptr[7:0]};
        end
    end

    sd_pingpong_ram u_ram (
        .clk       (clk_ref),
        .rst       (rst),
        .i_wr_en   (w_ram_we),
        .i_wr_addr ({r_fill_bank, r_wr_ptr}),
        .i_wr_data (pix_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (wr_data)
    );

    always_ff @(posedge clk_ref or posedge rst) begin
        if (rst) begin
            r_fill_bank <= 1'b0;
            r_wr_ptr    <= 8'd0;
            r_pix_cnt   <= 32'd0;
            r_full      <= 2'b00;
            overflow    <= 1'b0;
        end else if (w_capture_ok) begin
            r_fill_bank <= 1'b0;
            r_wr_ptr    <= 8'd0;
            r_pix_cnt   <= 32'd0;
            r_full      <= 2'b00;
            overflow    <= 1'b0;
        end else begin
            r_full <= w_full_nxt;
            if (w_drop) begin
                overflow <= 1'b1;
            end
            if (w_ram_we) begin
                r_wr_ptr  <= r_wr_ptr + 8'd1;
                r_pix_cnt <= r_pix_cnt + 32'd1;
                if (r_wr_ptr == 8'hFF) begin
                    r_fill_bank <= ~r_fill_bank;
                end
            end
        end
    end

    always_ff @(posedge clk_ref or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_drain_bank <= 1'b0;
            r_rd_ptr     <= 9'd0;
            r_sec_idx    <= 16'd0;
            r_busy_d     <= 1'b0;
            wr_start_en  <= 1'b0;
            wr_sec_addr  <= 32'd0;
            frame_busy   <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            r_busy_d   <= wr_busy;
            frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_capture_ok) begin
                        frame_busy   <= 1'b1;
                        r_drain_bank <= 1'b0;
                        r_sec_idx    <= 16'd0;
                        r_state      <= S_WAIT_FULL;
                    end
                end
                S_WAIT_FULL: begin
                    if (r_full[r_drain_bank]) begin
                        r_rd_ptr    <= 9'd0;
                        wr_sec_addr <= START_SEC + {16'd0, r_sec_idx};
                        r_state     <= S_START;
                    end
                end
                S_START: begin
                    // Held until the engine's synchroniser has seen the edge and reports busy.
                    if (wr_start_en && wr_busy) begin
                        wr_start_en <= 1'b0;
                        r_state     <= S_XFER;
                    end else begin
                        wr_start_en <= 1'b1;
                    end
                end
                S_XFER: begin
                    if (wr_req && !r_rd_ptr[8]) begin
                        r_rd_ptr <= r_rd_ptr + 9'd1;
                    end
                    if (r_busy_d && !wr_busy) begin
                        r_state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    r_drain_bank <= ~r_drain_bank;
                    r_sec_idx    <= w_sec_next;
                    if (w_sec_next < SEC_NUM) begin
                        r_state <= S_WAIT_FULL;
                    end else begin
                        frame_done <= 1'b1;
                        frame_busy <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
